// File: rtl/pipelined_add_sub.sv
// rtl/pipelined_add_sub.sv - STAGES-deep carry-chunked add/subtract unit with valid/ready handshake
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int C = WIDTH / STAGES;

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added (chunk k and above) and result bits done so far
        localparam int HI = (STAGES - k) * C;
        logic [HI-1:0]      a_i;
        logic [HI-1:0]      b_i;
        logic               c_i;
        logic               v_i;
        logic [C:0]         chunk;
        logic [(k+1)*C-1:0] s_i;

        if (k == 0) begin : g_in
            assign a_i = a;
            assign b_i = sub ? ~b : b;
            assign c_i = sub | cin;
            assign v_i = in_valid;
            assign s_i = chunk[C-1:0];
        end else begin : g_in
            assign a_i = g_stage[k-1].g_reg.a_r;
            assign b_i = g_stage[k-1].g_reg.b_r;
            assign c_i = g_stage[k-1].g_reg.c_r;
            assign v_i = g_stage[k-1].g_reg.v_r;
            assign s_i = {chunk[C-1:0], g_stage[k-1].g_reg.s_r};
        end

        assign chunk = {1'b0, a_i[C-1:0]} + {1'b0, b_i[C-1:0]} + {{C{1'b0}}, c_i};

        if (k < STAGES - 1) begin : g_reg
            logic [HI-C-1:0]    a_r;
            logic [HI-C-1:0]    b_r;
            logic               c_r;
            logic               v_r;
            logic [(k+1)*C-1:0] s_r;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_r <= 1'b0;
                    a_r <= '0;
                    b_r <= '0;
                    c_r <= 1'b0;
                    s_r <= '0;
                end else if (advance) begin
                    v_r <= v_i;
                    a_r <= a_i[HI-1:C];
                    b_r <= b_i[HI-1:C];
                    c_r <= chunk[C];
                    s_r <= s_i;
                end
            end
        end else begin : g_out
            // Result registers only load on a real op so they stay 0 until the first result
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                    zero      <= 1'b0;
                end else if (advance) begin
                    out_valid <= v_i;
                    if (v_i) begin
                        sum  <= s_i;
                        cout <= chunk[C];
                        ovf  <= a_i[C-1] ^ b_i[C-1] ^ s_i[WIDTH-1] ^ chunk[C];
                        zero <= ~|s_i;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// tb/tb_pipelined_add_sub.sv - scoreboard bench for pipelined_add_sub in 32/4 and 4/2 configurations
module tb_pipelined_add_sub;
    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, sum;
    logic        in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4, zero4;
    logic [3:0]  a4, b4, sum4;

    int          checks = 0;
    int          errors = 0;
    exp_t        q32[$];
    exp_t        q4[$];
    exp_t        e32, e4;
    bit          rand_ready = 1'b0;
    logic        hold_v = 1'b0;
    logic [35:0] held;
    logic [31:0] corners [5];
    logic [31:0] ra, rb;
    int          lat;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_add_sub #(.WIDTH(4), .STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .sum(sum4), .cout(cout4), .ovf(ovf4), .zero(zero4)
    );

    // Reference: plain integer arithmetic, unsigned for sum/carry, signed range test for overflow
    function automatic exp_t model(int w, longint av, longint bv, bit c, bit s);
        longint m    = longint'(1) << w;
        longint half = m >> 1;
        longint full, sa, sb, r;
        exp_t   e;
        full   = s ? (av + m - bv) : (av + bv + longint'(c));
        e.sum  = 32'(full % m);
        e.cout = (full >= m);
        sa     = (av >= half) ? av - m : av;
        sb     = (bv >= half) ? bv - m : bv;
        r      = s ? (sa - sb) : (sa + sb + longint'(c));
        e.ovf  = (r >= half) || (r < -half);
        e.zero = ((full % m) == 0);
        return e;
    endfunction

    task automatic send32(input logic [31:0] av, input logic [31:0] bv, input logic c, input logic s);
        int n = 0;
        @(negedge clk);
        a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send32_timeout: in_ready=%0b required 1", in_ready);
        end else begin
            q32.push_back(model(32, longint'(av), longint'(bv), c, s));
        end
    endtask

    task automatic idle32();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send4(input logic [3:0] av, input logic [3:0] bv, input logic c, input logic s);
        int n = 0;
        @(negedge clk);
        a4 = av; b4 = bv; cin4 = c; sub4 = s; in_valid4 = 1'b1;
        #1;
        while (!in_ready4 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready4) begin
            checks++; errors++;
            $display("FAIL send4_timeout: in_ready=%0b required 1", in_ready4);
        end else begin
            q4.push_back(model(4, longint'(av), longint'(bv), c, s));
        end
    endtask

    task automatic idle4();
        @(negedge clk);
        in_valid4 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q4.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q32.size() != 0 || q4.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d/%0d required 0/0", q32.size(), q4.size());
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor for the 32-bit unit: scoreboard pop, backpressure and hold-stability
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    checks++;
                    if ({out_valid, sum, cout, ovf, zero} !== held) begin
                        errors++;
                        $display("FAIL hold32: outputs=%h required %h", {out_valid, sum, cout, ovf, zero}, held);
                    end
                end
                if (out_valid && !out_ready) begin
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL backpressure32: in_ready=%0b required 0", in_ready);
                    end
                end
                hold_v = out_valid && !out_ready;
                held   = {out_valid, sum, cout, ovf, zero};
                if (out_valid && out_ready) begin
                    checks++;
                    if (q32.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected32: sum=%h with no result pending", sum);
                    end else begin
                        e32 = q32.pop_front();
                        if (sum !== e32.sum || cout !== e32.cout || ovf !== e32.ovf || zero !== e32.zero) begin
                            errors++;
                            $display("FAIL result32: sum=%h c=%0b v=%0b z=%0b required sum=%h c=%0b v=%0b z=%0b",
                                     sum, cout, ovf, zero, e32.sum, e32.cout, e32.ovf, e32.zero);
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid4 && out_ready4) begin
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected4: sum=%h with no result pending", sum4);
                end else begin
                    e4 = q4.pop_front();
                    if (sum4 !== e4.sum[3:0] || cout4 !== e4.cout || ovf4 !== e4.ovf || zero4 !== e4.zero) begin
                        errors++;
                        $display("FAIL result4: sum=%h c=%0b v=%0b z=%0b required sum=%h c=%0b v=%0b z=%0b",
                                 sum4, cout4, ovf4, zero4, e4.sum[3:0], e4.cout, e4.ovf, e4.zero);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'h7FFFFFFF;
        corners[3] = 32'h80000000; corners[4] = 32'hFFFFFFFF;

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, sum, cout, ovf, zero, in_ready} !== {35'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset32: v=%0b sum=%h c=%0b o=%0b z=%0b rdy=%0b required all 0, rdy=1",
                     out_valid, sum, cout, ovf, zero, in_ready);
        end
        checks++;
        if ({out_valid4, sum4, cout4, ovf4, zero4, in_ready4} !== {7'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset4: v=%0b sum=%h rdy=%0b required 0,0,1", out_valid4, sum4, in_ready4);
        end
        rst = 1'b0;

        send32(32'd2, 32'd6, 1'b0, 1'b0);
        idle32();
        #1;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL latency32: cycles=%0d required 4", lat);
        end

        send32(32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
        send32(32'd3, 32'd10, 1'b0, 1'b1);
        send32(32'h80000000, 32'd1, 1'b0, 1'b1);
        send32(32'h7FFFFFFF, 32'd1, 1'b0, 1'b0);
        send32(32'd15, 32'd0, 1'b1, 1'b0);
        send32(32'd5, 32'd5, 1'b1, 1'b1);
        idle32();

        send4(4'd2, 4'd6, 1'b0, 1'b0);
        idle4();
        #1;
        lat = 1;
        while (!out_valid4 && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL latency4: cycles=%0d required 2", lat);
        end
        send4(4'd15, 4'd1, 1'b0, 1'b0);
        send4(4'd3, 4'd10, 1'b0, 1'b1);
        send4(4'd8, 4'd1, 1'b0, 1'b1);
        send4(4'd7, 4'd1, 1'b0, 1'b0);
        send4(4'd15, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            send4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        end
        idle4();
        drain();

        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send32($urandom, $urandom, 1'($urandom), 1'($urandom));
        end
        idle32();
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle32();
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            send32(ra, rb, 1'($urandom), 1'($urandom));
        end
        idle32();
        rand_ready = 1'b0;
        drain();

        send32(32'd11, 32'd22, 1'b0, 1'b0);
        send32(32'd33, 32'd44, 1'b0, 1'b0);
        send32(32'd55, 32'd66, 1'b0, 1'b0);
        idle32();
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL inflight32: out_valid=%0b required 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, sum, cout, ovf, zero} !== 35'b0) begin
            errors++;
            $display("FAIL async_reset32: v=%0b sum=%h c=%0b o=%0b z=%0b required all 0",
                     out_valid, sum, cout, ovf, zero);
        end
        q32.delete();
        q4.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL stale_after_reset: out_valid=%0b/%0b required 0/0", out_valid, out_valid4);
        end

        send32(32'd100, 32'd1, 1'b0, 1'b1);
        idle32();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
